sipo_receiver: RTL and testbench
================================

# sipo_receiver

Serial-in/parallel-out receiver that consumes the 1-bit stream produced by the team's parallel-in/serial-out shift registers and rebuilds WIDTH-bit words. It sits directly downstream of the PISO stage. A shift register and bit counter assemble each word. Completed words go into an output holding register behind a valid/ready handshake, and an overrun flag records words lost to back-pressure.

## Interface
- WIDTH, 4, word width in bits; legal range 2..32.
- MSB_FIRST, 1. When 1, the first received bit becomes dout[WIDTH-1]; this matches PISO order. When 0, the first received bit becomes dout[0].
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- sin  in  1  serial data bit.
- sin_valid  in  1  sin is sampled on this edge only when high.
- frame_start  in  1  word-alignment strobe; discards any partial word.
- dout  out  WIDTH  assembled word held in the output register.
- dout_valid  out  1  output register holds an unread word.
- dout_ready  in  1  consumer accepts dout on an edge where dout_valid=1.
- overrun  out  1  sticky; a completed word was dropped.
- clr_overrun  in  1  clears overrun.
- bit_cnt  out  $clog2(WIDTH)  number of bits of the current partial word received so far.

## Operation
- State: shift register sr[WIDTH-1:0], bit counter bit_cnt, output register dout, flags dout_valid and overrun.
- Sample (sin_valid=1):
  - If MSB_FIRST: sr <= {sr[WIDTH-2:0], sin}.
  - Else: sr <= {sin, sr[WIDTH-1:1]}.
  - bit_cnt increments.
- Completion: a sample taken while bit_cnt==WIDTH-1 completes a word.
  - The completed word is the shifted value including the current sin.
  - bit_cnt wraps to 0 and sr is not cleared.
- On completion, if the output register is free (dout_valid=0, or dout_valid=1 and dout_ready=1 on the same edge):
  - dout <= completed word.
  - dout_valid <= 1.
- On completion otherwise (output register full and not being read):
  - The word is dropped.
  - overrun <= 1.
  - dout is unchanged.
- Pop: dout_valid=1 and dout_ready=1 with no completion on the same edge gives dout_valid <= 0. dout keeps its last value.
- frame_start=1 with sin_valid=1: the current bit is bit 0 of a new word. Any partial word is discarded and bit_cnt <= 1. No completion occurs on that edge, even if bit_cnt was WIDTH-1.
- frame_start=1 with sin_valid=0: bit_cnt <= 0 and the partial word is discarded.
- frame_start never affects dout, dout_valid or overrun.
- sin_valid=0 and frame_start=0: sr and bit_cnt hold. Gaps of any length between bits are legal.
- overrun:
  - Set by a dropped word.
  - Cleared by clr_overrun.
  - When a drop and clr_overrun coincide on one edge, set wins.
- dout_ready while dout_valid=0 has no effect.

## Timing
- Reset values: sr=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0. The async assert takes effect immediately; release is synchronous to clk.
- Reset mid-word discards the partial word. The first valid bit after release is bit 0.
- Latency: dout and dout_valid update on the same edge that samples the final bit of a word; they are visible in the following cycle.
- Throughput: one word every WIDTH sin_valid cycles. Continuous traffic with dout_ready tied high never overruns.
- A simultaneous completion and pop both take effect. dout is replaced and dout_valid stays 1 with no bubble.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Continuous stream, ready held at 1:
  - Stimulus: WIDTH=4, MSB_FIRST=1, dout_ready=1, sin=1,0,1,1 on 4 consecutive sin_valid cycles.
  - Required: dout=4'b1011 and dout_valid=1 the cycle after the 4th bit; dout_valid=0 one cycle later.
  - Rerun with MSB_FIRST=0: dout=4'b1101.
- Back-pressure and overrun:
  - Stimulus: dout_ready=0, send 4'hA, then 4'h5.
  - Required: dout stays 4'hA, dout_valid stays 1, overrun=1 after the 8th bit.
  - Then pulse dout_ready: dout_valid goes to 0. Then pulse clr_overrun: overrun goes to 0.
- Simultaneous pop and completion:
  - Stimulus: holding 4'h3, send 4'hC, and assert dout_ready exactly on the 4th-bit edge.
  - Required: dout=4'hC, dout_valid remains 1, overrun=0.
- Resync mid-word:
  - Stimulus: send 2 bits (1,1), then frame_start=1 with sin_valid=1 and sin=0, then bits 1,1,0.
  - Required: dout=4'b0110, bit_cnt read 1 after the frame_start edge.
  - Also: frame_start without sin_valid sets bit_cnt=0.
- Gapped input and reset:
  - Stimulus: send 4'h9 with random 0-5 cycle sin_valid gaps.
  - Required: dout=4'h9.
  - Then assert rst mid-word after 2 bits: all outputs go to 0 immediately. The next 4 bits 0,1,1,1 yield dout=4'h7.

Source files
------------

// File: rtl/sipo_receiver_if.sv
// Serial receiver bus: the bit stream and alignment strobe in, the assembled word
// with its valid/ready handshake, the overrun flag and the bit counter out.
interface sipo_receiver_if #(
  parameter int WIDTH = 4
);
  localparam int CNT_W = $clog2(WIDTH);

  logic             sin;
  logic             sin_valid;
  logic             frame_start;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic             overrun;
  logic             clr_overrun;
  logic [CNT_W-1:0] bit_cnt;

  // Upstream PISO / consumer side: drives the stream and the handshake controls.
  modport master (
    output sin, sin_valid, frame_start, dout_ready, clr_overrun,
    input  dout, dout_valid, overrun, bit_cnt
  );

  // Receiver side.
  modport slave (
    input  sin, sin_valid, frame_start, dout_ready, clr_overrun,
    output dout, dout_valid, overrun, bit_cnt
  );
endinterface

// File: rtl/sipo_receiver.sv
// Serial-in/parallel-out receiver. It rebuilds WIDTH-bit words from the PISO bit
// stream, holds each finished word in an output register behind valid/ready, and
// sets a sticky overrun flag when a finished word finds that register occupied.
module sipo_receiver #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  sipo_receiver_if.slave  bus
);
  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             out_free;
  logic             drop;

  // Shift one bit into the assembly register in the configured bit order.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                input logic             b);
    if (MSB_FIRST)
      return {sr[WIDTH-2:0], b};
    else
      return {b, sr[WIDTH-1:1]};
  endfunction

  // Next-state: word assembly, alignment, completion, handshake and overrun.
  always_comb begin
    sr_d         = sr_q;
    bit_cnt_d    = bit_cnt_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
    complete     = 1'b0;
    drop         = 1'b0;

    shifted  = shift_in(sr_q, bus.sin);
    out_free = !dout_valid_q || bus.dout_ready;

    // The assembly register is never cleared: a full word of shifts always
    // flushes older bits, so discarding a partial word only needs the counter.
    if (bus.frame_start) begin
      if (bus.sin_valid) begin
        sr_d      = shifted;
        bit_cnt_d = CNT_W'(1);
      end else begin
        bit_cnt_d = '0;
      end
    end else if (bus.sin_valid) begin
      sr_d = shifted;
      if (bit_cnt_q == LAST_BIT) begin
        complete  = 1'b1;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
    end

    // A completion that coincides with a pop reloads without a bubble.
    if (complete && out_free) begin
      dout_d       = shifted;
      dout_valid_d = 1'b1;
    end else if (complete) begin
      drop = 1'b1;
    end else if (dout_valid_q && bus.dout_ready) begin
      dout_valid_d = 1'b0;
    end

    // Set wins over clear so a drop on the clearing edge is never lost.
    if (bus.clr_overrun)
      overrun_d = 1'b0;
    if (drop)
      overrun_d = 1'b1;
  end

  // State registers with asynchronous assert, clock-synchronous release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q         <= '0;
      bit_cnt_q    <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sr_q         <= sr_d;
      bit_cnt_q    <= bit_cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.bit_cnt    = bit_cnt_q;
endmodule

// File: tb/tb_sipo_receiver.sv
// Directed bench for sipo_receiver: an MSB-first and an LSB-first instance share
// one stimulus stream; expected MSB-first words go through a scoreboard queue.
module tb_sipo_receiver;
  logic clk;
  logic rst;

  sipo_receiver_if #(.WIDTH(4)) ifm ();
  sipo_receiver_if #(.WIDTH(4)) ifl ();

  sipo_receiver #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk (clk),
    .rst (rst),
    .bus (ifm.slave)
  );

  sipo_receiver #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk (clk),
    .rst (rst),
    .bus (ifl.slave)
  );

  assign ifl.sin         = ifm.sin;
  assign ifl.sin_valid   = ifm.sin_valid;
  assign ifl.frame_start = ifm.frame_start;
  assign ifl.dout_ready  = ifm.dout_ready;
  assign ifl.clr_overrun = ifm.clr_overrun;

  int n_pass;
  int n_total;
  logic [3:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // Pop the next expected word and compare it against the MSB-first output.
  task automatic check_dout(input string tag);
    logic [3:0] e;
    if (exp_q.size() == 0) begin
      n_total++;
      $error("FAIL %s observed=scoreboard_empty expected=queued_word", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(ifm.dout_valid), 32'd1);
      check({tag, "_dout"}, 32'(ifm.dout), 32'(e));
    end
  endtask

  // One sin_valid cycle; returns 1 ns after the sampling edge.
  task automatic send_bit(input logic b);
    ifm.sin       = b;
    ifm.sin_valid = 1'b1;
    @(posedge clk);
    #1;
    ifm.sin_valid = 1'b0;
  endtask

  // Send a word MSB of the argument first, with up to max_gap idle cycles between bits.
  task automatic send_word(input logic [3:0] w, input int max_gap);
    logic [3:0] v;
    v = w;
    for (int i = 3; i >= 0; i--) begin
      send_bit(v[i]);
      if (i != 0 && max_gap > 0) begin
        int g;
        g = $urandom_range(max_gap, 0);
        for (int k = 0; k < g; k++) begin
          @(posedge clk);
          #1;
        end
      end
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    ifm.sin         = 1'b0;
    ifm.sin_valid   = 1'b0;
    ifm.frame_start = 1'b0;
    ifm.dout_ready  = 1'b0;
    ifm.clr_overrun = 1'b0;

    // Reset state
    idle_cycle();
    idle_cycle();
    check("rst_dout", 32'(ifm.dout), 32'd0);
    check("rst_valid", 32'(ifm.dout_valid), 32'd0);
    check("rst_overrun", 32'(ifm.overrun), 32'd0);
    check("rst_bit_cnt", 32'(ifm.bit_cnt), 32'd0);
    rst = 1'b0;
    idle_cycle();

    // Continuous stream with ready held high, both bit orders
    ifm.dout_ready = 1'b1;
    exp_q.push_back(4'b1011);
    send_word(4'b1011, 0);
    check_dout("cont_msb");
    check("cont_lsb_valid", 32'(ifl.dout_valid), 32'd1);
    check("cont_lsb_dout", 32'(ifl.dout), 32'h0000000d);
    idle_cycle();
    check("cont_pop_msb", 32'(ifm.dout_valid), 32'd0);
    check("cont_pop_lsb", 32'(ifl.dout_valid), 32'd0);

    // Back-pressure: second word is dropped and flags overrun
    ifm.dout_ready = 1'b0;
    exp_q.push_back(4'hA);
    send_word(4'hA, 0);
    check("bp_first_valid", 32'(ifm.dout_valid), 32'd1);
    check("bp_no_overrun", 32'(ifm.overrun), 32'd0);
    send_word(4'h5, 0);
    check_dout("bp_hold");
    check("bp_overrun", 32'(ifm.overrun), 32'd1);
    ifm.dout_ready = 1'b1;
    idle_cycle();
    ifm.dout_ready = 1'b0;
    check("bp_pop_valid", 32'(ifm.dout_valid), 32'd0);
    check("bp_overrun_sticky", 32'(ifm.overrun), 32'd1);
    check("bp_dout_kept", 32'(ifm.dout), 32'h0000000a);
    ifm.clr_overrun = 1'b1;
    idle_cycle();
    ifm.clr_overrun = 1'b0;
    check("clr_overrun", 32'(ifm.overrun), 32'd0);

    // Simultaneous pop and completion
    exp_q.push_back(4'h3);
    send_word(4'h3, 0);
    check_dout("sim_hold");
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    ifm.dout_ready = 1'b1;
    exp_q.push_back(4'hC);
    send_bit(1'b0);
    ifm.dout_ready = 1'b0;
    check_dout("sim_replace");
    check("sim_no_overrun", 32'(ifm.overrun), 32'd0);
    ifm.dout_ready = 1'b1;
    idle_cycle();
    check("sim_pop_valid", 32'(ifm.dout_valid), 32'd0);

    // Resync mid-word
    send_bit(1'b1);
    send_bit(1'b1);
    ifm.frame_start = 1'b1;
    send_bit(1'b0);
    ifm.frame_start = 1'b0;
    check("resync_bit_cnt", 32'(ifm.bit_cnt), 32'd1);
    exp_q.push_back(4'b0110);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    check_dout("resync_word");
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    check("fs_pre_bit_cnt", 32'(ifm.bit_cnt), 32'd3);
    ifm.frame_start = 1'b1;
    send_bit(1'b1);
    ifm.frame_start = 1'b0;
    check("fs_last_bit_cnt", 32'(ifm.bit_cnt), 32'd1);
    check("fs_no_completion", 32'(ifm.dout_valid), 32'd0);
    send_bit(1'b0);
    check("fs_mid_bit_cnt", 32'(ifm.bit_cnt), 32'd2);
    ifm.frame_start = 1'b1;
    idle_cycle();
    ifm.frame_start = 1'b0;
    check("fs_novalid_bit_cnt", 32'(ifm.bit_cnt), 32'd0);
    check("fs_overrun_untouched", 32'(ifm.overrun), 32'd0);

    // Gapped input
    exp_q.push_back(4'h9);
    send_word(4'h9, 5);
    check_dout("gapped");

    // Asynchronous reset mid-word
    send_bit(1'b1);
    send_bit(1'b1);
    check("pre_rst_bit_cnt", 32'(ifm.bit_cnt), 32'd2);
    check("pre_rst_dout", 32'(ifm.dout), 32'h00000009);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_dout", 32'(ifm.dout), 32'd0);
    check("async_rst_valid", 32'(ifm.dout_valid), 32'd0);
    check("async_rst_overrun", 32'(ifm.overrun), 32'd0);
    check("async_rst_bit_cnt", 32'(ifm.bit_cnt), 32'd0);
    idle_cycle();
    rst = 1'b0;
    exp_q.push_back(4'h7);
    send_word(4'h7, 0);
    check_dout("post_rst");
    check("post_rst_lsb", 32'(ifl.dout), 32'h0000000e);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
